// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared types and helpers for the sequential binary-to-BCD converter.
// Holds the FSM state encoding, the BCD nibble type and the minimum-digit rule.
package bin_to_bcd_seq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    typedef logic [3:0] nibble_t;

    // Decimal digits needed for 2**bits-1, i.e. ceil(bits*log10(2)), in integer arithmetic.
    function automatic int min_digits(input int bits);
        return (bits * 30103 + 99999) / 100000;
    endfunction

endpackage

// File: rtl/bcd_add3_nibble.sv
// Double-dabble correction for one BCD digit: values of 5 and above get +3.
// The result stays inside its own nibble; no carry is produced.
module bcd_add3_nibble
    import bin_to_bcd_seq_pkg::*;
(
    input  nibble_t value,
    output nibble_t adjusted
);

    assign adjusted = (value >= nibble_t'(5)) ? nibble_t'(value + nibble_t'(3)) : value;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one input bit per clock.
// The bcd output register only updates when a conversion completes.
module bin_to_bcd_seq
    import bin_to_bcd_seq_pkg::*;
#(
    parameter int BITS   = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [BITS-1:0]       bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd
);

    localparam int BCD_W  = 4 * DIGITS;
    localparam int WORK_W = BCD_W + BITS;
    localparam int CNT_W  = $clog2(BITS + 1);

    generate
        if (DIGITS < min_digits(BITS)) begin : g_digits_check
            $error("bin_to_bcd_seq: DIGITS too small for BITS");
        end
    endgenerate

    state_t              state_q, state_d;
    logic [WORK_W-1:0]   work_q, adjusted, shifted;
    logic [CNT_W-1:0]    cnt_q;
    logic [BCD_W-1:0]    bcd_q;
    logic                load, shift_en, last_shift;

    // Working register layout: {BCD digits, remaining binary bits}.
    assign adjusted[BITS-1:0] = work_q[BITS-1:0];

    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
        bcd_add3_nibble u_add3 (
            .value    (work_q[BITS+4*k +: 4]),
            .adjusted (adjusted[BITS+4*k +: 4])
        );
    end

    assign shifted    = adjusted << 1;
    assign last_shift = (cnt_q == CNT_W'(1));

    // NOTE: sequential blocks use non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // NOTE: every output of this always_comb gets a default first, so no latch is inferred.
    always_comb begin
        state_d  = state_q;
        load     = 1'b0;
        shift_en = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                shift_en = 1'b1;
                if (last_shift) state_d = DONE;
            end
            DONE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            work_q <= '0;
            cnt_q  <= '0;
            bcd_q  <= '0;
        end else if (load) begin
            work_q <= {{BCD_W{1'b0}}, bin_in};
            cnt_q  <= CNT_W'(BITS);
        end else if (shift_en) begin
            work_q <= shifted;
            cnt_q  <= cnt_q - 1'b1;
            if (last_shift) bcd_q <= shifted[WORK_W-1 -: BCD_W];
        end
    end

    assign busy = (state_q == SHIFT);
    assign done = (state_q == DONE);
    assign bcd  = bcd_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq against a decimal-arithmetic reference.
// Covers latency, ignored starts, back-to-back runs, mid-run reset and a full sweep.
module tb_bin_to_bcd_seq;

    localparam int BITS   = 8;
    localparam int DIGITS = 3;
    localparam int BCD_W  = 4 * DIGITS;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [BITS-1:0]   bin_in;
    logic              busy;
    logic              done;
    logic [BCD_W-1:0]  bcd;

    int checks = 0;
    int errors = 0;

    bin_to_bcd_seq #(.BITS(BITS), .DIGITS(DIGITS)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .bin_in (bin_in),
        .busy   (busy),
        .done   (done),
        .bcd    (bcd)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: each digit straight from decimal division.
    function automatic logic [BCD_W-1:0] ref_bcd(input int value);
        logic [BCD_W-1:0] r;
        int               v;
        r = '0;
        v = value;
        for (int k = 0; k < DIGITS; k++) begin
            r[4*k +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic logic digits_ok(input logic [BCD_W-1:0] b);
        for (int k = 0; k < DIGITS; k++)
            if (b[4*k +: 4] > 4'd9) return 1'b0;
        return 1'b1;
    endfunction

    // One conversion; optional stray start at cycle inject_at while busy.
    task automatic run_conv(input int value, input int inject_at, input int inject_val,
                            input string tag);
        int               lat, busy_n, extra;
        logic             stable;
        logic [BCD_W-1:0] expv;
        expv = ref_bcd(value);
        @(negedge clk);
        start  = 1'b1;
        bin_in = value[BITS-1:0];
        @(negedge clk);
        start  = 1'b0;
        lat    = 0;
        busy_n = 0;
        for (int i = 1; i <= 30; i++) begin
            if (busy) busy_n++;
            if (done) begin
                lat = i;
                break;
            end
            if (i == inject_at) begin
                start  = 1'b1;
                bin_in = inject_val[BITS-1:0];
            end else begin
                start  = 1'b0;
                bin_in = BITS'($urandom);
            end
            @(negedge clk);
        end
        check({tag, " latency"}, lat, BITS + 1);
        check({tag, " busy_cycles"}, busy_n, BITS);
        check({tag, " bcd"}, 32'(bcd), 32'(expv));
        check({tag, " digits<=9"}, 32'(digits_ok(bcd)), 1);
        extra  = 0;
        stable = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (done) extra++;
            if (bcd !== expv) stable = 1'b0;
        end
        check({tag, " extra_done"}, extra, 0);
        check({tag, " bcd_hold"}, 32'(stable), 1);
    endtask

    task automatic run_back_to_back();
        int               vals[2];
        int               n, t_first, t_second;
        logic             stable;
        logic [BCD_W-1:0] last;
        vals     = '{13, 21};
        n        = 0;
        t_first  = 0;
        t_second = 0;
        stable   = 1'b1;
        last     = bcd;
        @(negedge clk);
        start  = 1'b1;
        bin_in = BITS'(vals[0]);
        @(negedge clk);
        for (int i = 1; i <= 40 && n < 2; i++) begin
            if (done) begin
                check($sformatf("b2b bcd%0d", n), 32'(bcd), 32'(ref_bcd(vals[n])));
                if (n == 0) t_first = i;
                else        t_second = i;
                last = bcd;
                n++;
                if (n == 1) bin_in = BITS'(vals[1]);
                else        start = 1'b0;
            end else begin
                if (bcd !== last) stable = 1'b0;
                bin_in = BITS'($urandom);
            end
            @(negedge clk);
        end
        start = 1'b0;
        check("b2b first_latency", t_first, BITS + 1);
        check("b2b pulse_gap", t_second - t_first, BITS + 1);
        check("b2b bcd_hold", 32'(stable), 1);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        bin_in = '0;
        repeat (3) @(negedge clk);
        check("reset busy", 32'(busy), 0);
        check("reset done", 32'(done), 0);
        check("reset bcd", 32'(bcd), 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle busy", 32'(busy), 0);

        run_conv(0,   0, 0, "v0");
        run_conv(255, 0, 0, "v255");
        run_conv(144, 0, 0, "v144");
        run_conv(89,  0, 0, "v89");
        run_conv(200, 3, 7, "ignore_start");

        run_back_to_back();

        // Mid-conversion reset must clear outputs asynchronously.
        run_conv(55, 0, 0, "v55");
        @(negedge clk);
        start  = 1'b1;
        bin_in = 8'd233;
        @(negedge clk);
        start  = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort busy", 32'(busy), 0);
        check("abort done", 32'(done), 0);
        check("abort bcd", 32'(bcd), 0);
        @(negedge clk);
        rst = 1'b0;
        run_conv(233, 0, 0, "after_abort");

        for (int v = 0; v < (1 << BITS); v++)
            run_conv(v, 0, 0, $sformatf("sweep%0d", v));

        for (int r = 0; r < 30; r++)
            run_conv(int'($urandom_range(0, (1 << BITS) - 1)), int'($urandom_range(1, 6)),
                     int'($urandom_range(0, 255)), $sformatf("rand%0d", r));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bin_to_bcd_seq.md
Name: bin_to_bcd_seq

Overview:
Sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm, one bit per clock. It sits directly downstream of the processor's output register (e.g. the 8-bit Ro of the Fibonacci program) and upstream of sev_seg_controller. Results are displayed in decimal instead of hex. It presents each decimal digit as a 4-bit nibble ready to drive a seven-segment digits[] slot.

Parameters:
BITS, 8, width of the binary input.
DIGITS, 3, number of BCD output digits. Must be at least ceil(BITS*log10(2)); a smaller value is an elaboration-time error.

Ports:
clk  input  1  system clock.
rst  input  1  asynchronous reset, active-high.
start  input  1  request a conversion of bin_in. Sampled only in IDLE or DONE.
bin_in  input  BITS  unsigned binary value. Captured on the accepting edge only.
busy  output  1  high while a conversion is in progress (SHIFT state).
done  output  1  one-cycle pulse; bcd is valid and newly updated.
bcd  output  4*DIGITS  result; digit k in bits [4k+3:4k], k=0 is the ones digit.

Behaviour:
- Reset is asynchronous and active-high. While rst=1 the block forces:
  - state=IDLE, busy=0, done=0, bcd=0;
  - shift register=0, bit counter=0.
- States:
  - IDLE: busy=0, done=0.
  - SHIFT: busy=1, done=0.
  - DONE: busy=0, done=1, lasting exactly one cycle.
- Transitions:
  - IDLE, start=1: load the working register = {4*DIGITS zeros, bin_in}, set counter=BITS, go to SHIFT. With start=0, stay in IDLE.
  - SHIFT, each cycle: apply add-3 to every BCD nibble of the working register whose value is >=5, then shift the whole register left by 1 and decrement the counter.
  - SHIFT, counter reaching 0: on the edge that performs the final (BITS-th) shift, copy the BCD field into the bcd output register and go to DONE.
  - DONE, start=1: reload exactly as from IDLE and go to SHIFT (back-to-back conversion). With start=0, go to IDLE.
- Latency: with start accepted at edge T0, busy=1 for cycles T0+1 .. T0+BITS and done=1 in cycle T0+BITS+1. For BITS=8, done is high in the 9th cycle after acceptance.
- start while busy=1 is ignored and not queued; bin_in changes during SHIFT have no effect.
- bcd changes only on entry to DONE and holds its last result otherwise, so the display never shows partial values.
- Width rules:
  - working register width = 4*DIGITS + BITS;
  - add-3 is applied per nibble and never carries between nibbles;
  - every output nibble is always in the range 0..9.
- Reset asserted mid-conversion aborts immediately: outputs go to their reset values and the partial result is discarded.
- No combinational path from start or bin_in to any output; all outputs are registered.

Decomposition:
- Shared package: state enum typedef (IDLE, SHIFT, DONE), a nibble typedef (logic [3:0]), and a function computing the minimum DIGITS for a given BITS, used by the elaboration check.
- One natural sub-module: bcd_add3_nibble, a combinational block (in <5 -> in, else in+3), instantiated DIGITS times inside the shift datapath.

Test Plan:
- Reset then bin_in=0, start pulse -> done at cycle 9, bcd=12'h000, busy high for exactly 8 cycles.
- bin_in=255 -> bcd=12'h255; bin_in=144 -> bcd=12'h144; bin_in=89 -> bcd=12'h089.
- Start with bin_in=200; at cycle 3 assert start with bin_in=7 -> second start ignored, done once, bcd=12'h200.
- Hold start=1 continuously, changing bin_in to 13 then 21 at each done -> back-to-back conversions with done pulses 9 cycles apart and bcd=12'h013 then 12'h021; bcd stable between pulses.
- Complete bin_in=55 (bcd=12'h055), then start bin_in=233 and assert rst at cycle 4 -> bcd=0, busy=0, done=0 immediately; next start with 233 -> bcd=12'h233.
- Sweep 0..255 against a decimal reference model -> all digits match and every nibble stays <=9.
